// File: rtl/line_sum_generator.sv
// line_sum_generator
//
// Producer side of the line-sum path. It accepts a stream of unsigned pixel pairs, multiplies
// each pair, and accumulates the products over one image line of LINE_SIZE pixels. The
// completed sum goes into a one-entry output register, which the downstream consumer drains
// through a valid/ready handshake. The block also tracks the line position within a frame of
// NUM_OF_LINES lines. It flags the last line with line_last, and pulses frame_done for one
// cycle after that line has been consumed.
//
// Ports:
//   CLK            in   clock; all state changes on its rising edge
//   reset          in   synchronous, active-high reset
//   pixel_a        in   first operand, unsigned, PIXEL_SIZE bits
//   pixel_b        in   second operand, unsigned, PIXEL_SIZE bits
//   pixel_valid    in   pixel pair is valid this cycle
//   pixel_ready    out  pair is accepted this cycle (combinational from line_sum_ready)
//   line_sum       out  completed line sum, $clog2(LINE_SIZE)+2*PIXEL_SIZE bits
//   line_sum_valid out  line_sum / line_last are held for the consumer
//   line_sum_ready in   consumer accepts line_sum
//   line_last      out  line_sum belongs to line NUM_OF_LINES-1 of the frame
//   frame_done     out  one-cycle pulse after the last line of a frame is consumed
//
// The parameter defaults mirror the shared Parameters.svh values.

module line_sum_generator #(
    parameter int unsigned PIXEL_SIZE   = 8,
    parameter int unsigned LINE_SIZE    = 64,
    parameter int unsigned NUM_OF_LINES = 64
) (
    input  logic                                      CLK,
    input  logic                                      reset,
    input  logic [PIXEL_SIZE-1:0]                     pixel_a,
    input  logic [PIXEL_SIZE-1:0]                     pixel_b,
    input  logic                                      pixel_valid,
    output logic                                      pixel_ready,
    output logic [$clog2(LINE_SIZE)+2*PIXEL_SIZE-1:0] line_sum,
    output logic                                      line_sum_valid,
    input  logic                                      line_sum_ready,
    output logic                                      line_last,
    output logic                                      frame_done
);

    localparam int unsigned SumW  = $clog2(LINE_SIZE) + 2 * PIXEL_SIZE;
    localparam int unsigned ProdW = 2 * PIXEL_SIZE;
    localparam int unsigned ColW  = (LINE_SIZE > 1) ? $clog2(LINE_SIZE) : 1;
    localparam int unsigned RowW  = (NUM_OF_LINES > 1) ? $clog2(NUM_OF_LINES) : 1;

    localparam logic [ColW-1:0] LastCol = ColW'(LINE_SIZE - 1);
    localparam logic [RowW-1:0] LastRow = RowW'(NUM_OF_LINES - 1);

    logic [ColW-1:0] col_q, col_d;
    logic [RowW-1:0] row_q, row_d;
    logic [SumW-1:0] acc_q, acc_d;
    logic [SumW-1:0] sum_q, sum_d;
    logic            valid_q, valid_d;
    logic            last_q, last_d;
    logic            frame_done_q, frame_done_d;

    logic [ProdW-1:0] product_w;
    logic [SumW-1:0]  product;
    logic [SumW-1:0]  acc_sum;
    logic             at_last_col;
    logic             pixel_fire;
    logic             consume;

    // Operands are widened first so the multiply is done at the full product width.
    assign product_w = {{PIXEL_SIZE{1'b0}}, pixel_a} * {{PIXEL_SIZE{1'b0}}, pixel_b};
    assign product   = SumW'(product_w);

    assign at_last_col = (col_q == LastCol);
    assign consume     = valid_q && line_sum_ready;

    // Only the closing pixel of a line needs the output slot. It stalls only when the slot is
    // full and is not draining this cycle.
    assign pixel_ready = !reset && !(at_last_col && valid_q && !line_sum_ready);
    assign pixel_fire  = pixel_valid && pixel_ready;

    // Column 0 starts a fresh sum, so stale accumulator contents never leak between lines.
    // With LINE_SIZE == 1 the last column is also column 0, so the sum is just the product.
    assign acc_sum = (col_q == '0) ? product : (acc_q + product);

    always_comb begin
        col_d        = col_q;
        row_d        = row_q;
        acc_d        = acc_q;
        sum_d        = sum_q;
        last_d       = last_q;
        valid_d      = valid_q;
        frame_done_d = consume && last_q;

        // A consume frees the slot. A line completing on the same edge refills it below.
        if (consume) begin
            valid_d = 1'b0;
        end

        if (pixel_fire) begin
            if (at_last_col) begin
                sum_d   = acc_sum;
                last_d  = (row_q == LastRow);
                valid_d = 1'b1;
                col_d   = '0;
                row_d   = (row_q == LastRow) ? '0 : row_q + 1'b1;
            end else begin
                acc_d = acc_sum;
                col_d = col_q + 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            col_q        <= '0;
            row_q        <= '0;
            acc_q        <= '0;
            sum_q        <= '0;
            valid_q      <= 1'b0;
            last_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            acc_q        <= acc_d;
            sum_q        <= sum_d;
            valid_q      <= valid_d;
            last_q       <= last_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign line_sum       = sum_q;
    assign line_sum_valid = valid_q;
    assign line_last      = last_q;
    assign frame_done     = frame_done_q;

endmodule

// File: tb/tb_line_sum_generator.sv
// Testbench for line_sum_generator with LINE_SIZE=4, PIXEL_SIZE=8, NUM_OF_LINES=3.
// A reference model keeps accepted products per line and queues the expected line sums.
// A monitor checks every cycle against that model. Table vectors and hand-written sequences
// check fixed values.

module tb_line_sum_generator;

    localparam int unsigned PS = 8;
    localparam int unsigned LS = 4;
    localparam int unsigned NL = 3;
    localparam int unsigned SW = $clog2(LS) + 2 * PS;

    logic          CLK = 1'b0;
    logic          reset = 1'b1;
    logic [PS-1:0] pixel_a = '0;
    logic [PS-1:0] pixel_b = '0;
    logic          pixel_valid = 1'b0;
    logic          pixel_ready;
    logic [SW-1:0] line_sum;
    logic          line_sum_valid;
    logic          line_sum_ready = 1'b1;
    logic          line_last;
    logic          frame_done;

    line_sum_generator #(
        .PIXEL_SIZE  (PS),
        .LINE_SIZE   (LS),
        .NUM_OF_LINES(NL)
    ) dut (
        .CLK           (CLK),
        .reset         (reset),
        .pixel_a       (pixel_a),
        .pixel_b       (pixel_b),
        .pixel_valid   (pixel_valid),
        .pixel_ready   (pixel_ready),
        .line_sum      (line_sum),
        .line_sum_valid(line_sum_valid),
        .line_sum_ready(line_sum_ready),
        .line_last     (line_last),
        .frame_done    (frame_done)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;
    int stalls = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model + per-cycle monitor ----------------
    typedef struct {
        int unsigned sum;
        bit          last;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned cur_sum = 0;
    int          cur_cnt = 0;
    int          row = 0;
    bit          fd_exp = 0;
    bit          prev_hold = 0;
    int          prev_sum = 0;
    bit          prev_last = 0;
    bit          post_rst = 0;
    bit          mon_en = 0;

    task automatic model_flush();
        exp_q.delete();
        cur_sum   = 0;
        cur_cnt   = 0;
        row       = 0;
        fd_exp    = 0;
        prev_hold = 0;
    endtask

    // Inputs change on the falling edge. Sampling 1 time unit later sees exactly what the
    // next rising edge will act on.
    always @(negedge CLK) begin
        #1;
        if (mon_en) begin
            chk("valid_vs_model", int'(line_sum_valid), int'(exp_q.size() != 0));
            chk("frame_done", int'(frame_done), int'(fd_exp));
            if (prev_hold) begin
                chk("hold_sum", int'(line_sum), prev_sum);
                chk("hold_last", int'(line_last), int'(prev_last));
            end
            if (reset) begin
                chk("ready_in_reset", int'(pixel_ready), 0);
                model_flush();
                post_rst = 1;
            end else begin
                if (post_rst) begin
                    chk("post_rst_sum", int'(line_sum), 0);
                    chk("post_rst_last", int'(line_last), 0);
                    post_rst = 0;
                end
                chk("pixel_ready",
                    int'(pixel_ready),
                    int'(!(exp_q.size() != 0 && cur_cnt == LS - 1 && !line_sum_ready)));
                fd_exp = 0;
                if (line_sum_valid && line_sum_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_line", 1, 0);
                    end else begin
                        chk("model_sum", int'(line_sum), int'(exp_q[0].sum));
                        chk("model_last", int'(line_last), int'(exp_q[0].last));
                        fd_exp = exp_q[0].last;
                        void'(exp_q.pop_front());
                    end
                end
                prev_hold = line_sum_valid && !line_sum_ready;
                prev_sum  = int'(line_sum);
                prev_last = line_last;
                if (pixel_valid && pixel_ready) begin
                    cur_sum += int'(pixel_a) * int'(pixel_b);
                    cur_cnt++;
                    if (cur_cnt == LS) begin
                        exp_q.push_back('{sum: cur_sum, last: (row == NL - 1)});
                        row     = (row + 1) % NL;
                        cur_sum = 0;
                        cur_cnt = 0;
                    end
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    // Present one pair and return just after the edge that accepts it.
    task automatic send_pixel(input logic [PS-1:0] a, input logic [PS-1:0] b);
        int waited = 0;
        @(negedge CLK);
        pixel_a     = a;
        pixel_b     = b;
        pixel_valid = 1'b1;
        #1;
        while (!pixel_ready && waited < 50) begin
            @(negedge CLK);
            #1;
            waited++;
        end
        if (waited != 0) stalls++;
        if (!pixel_ready) begin
            chk("accept_timeout", 0, 1);
            pixel_valid = 1'b0;
        end else begin
            @(posedge CLK);
            #1 pixel_valid = 1'b0;
        end
    endtask

    task automatic send_line(input logic [31:0] a4, input logic [31:0] b4);
        for (int k = 0; k < 4; k++) send_pixel(a4[8*k+:8], b4[8*k+:8]);
    endtask

    typedef struct {
        logic [31:0] a4;
        logic [31:0] b4;
        int          sum;
        bit          last;
    } vec_t;

    vec_t vecs[6];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish before timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{a4: 32'hFFFFFFFF, b4: 32'hFFFFFFFF, sum: 260100, last: 0};
        vecs[1] = '{a4: 32'h04030201, b4: 32'h02020202, sum: 20,     last: 0};
        vecs[2] = '{a4: 32'h01010101, b4: 32'h01010101, sum: 4,      last: 1};
        vecs[3] = '{a4: 32'h281E140A, b4: 32'h02010003, sum: 140,    last: 0};
        vecs[4] = '{a4: 32'h01FF0007, b4: 32'hFF02C809, sum: 828,    last: 0};
        vecs[5] = '{a4: 32'h01010101, b4: 32'h01010101, sum: 4,      last: 1};

        // Reset state.
        repeat (2) @(negedge CLK);
        #1;
        chk("rst_ready", int'(pixel_ready), 0);
        chk("rst_valid", int'(line_sum_valid), 0);
        chk("rst_sum", int'(line_sum), 0);
        chk("rst_last", int'(line_last), 0);
        chk("rst_frame_done", int'(frame_done), 0);
        mon_en = 1;
        @(negedge CLK);
        reset = 1'b0;

        // Table vectors, gap-free with ready held high; two full frames.
        for (int i = 0; i < 6; i++) begin
            send_line(vecs[i].a4, vecs[i].b4);
            @(negedge CLK);
            #1;
            chk("tbl_valid", int'(line_sum_valid), 1);
            chk("tbl_sum", int'(line_sum), vecs[i].sum);
            chk("tbl_last", int'(line_last), int'(vecs[i].last));
            @(negedge CLK);
            #1;
            chk("tbl_valid_drop", int'(line_sum_valid), 0);
            chk("tbl_frame_done", int'(frame_done), int'(vecs[i].last));
        end

        // Same line as vecs[1] with pixel_valid gapped every other cycle (row 0).
        for (int k = 0; k < 4; k++) begin
            send_pixel(8'(k + 1), 8'd2);
            @(negedge CLK);
        end
        #1;
        chk("gap_sum", int'(line_sum), 20);
        chk("gap_last", int'(line_last), 0);

        // Backpressure: line 1 sum 20 held, line 2 stalls at its last pixel.
        @(negedge CLK);
        line_sum_ready = 1'b0;
        send_line(32'h04030201, 32'h02020202);
        @(negedge CLK);
        #1;
        chk("bp_sum0", int'(line_sum), 20);
        for (int k = 0; k < 3; k++) send_pixel(8'd1, 8'd1);
        @(negedge CLK);
        pixel_a     = 8'd1;
        pixel_b     = 8'd1;
        pixel_valid = 1'b1;
        #1;
        for (int k = 0; k < 4; k++) begin
            chk("bp_stall_ready", int'(pixel_ready), 0);
            chk("bp_hold_sum", int'(line_sum), 20);
            @(negedge CLK);
            #1;
        end
        @(negedge CLK);
        line_sum_ready = 1'b1;
        #1;
        chk("bp_release_ready", int'(pixel_ready), 1);
        @(posedge CLK);
        #1 pixel_valid = 1'b0;
        @(negedge CLK);
        #1;
        chk("bp_new_valid", int'(line_sum_valid), 1);
        chk("bp_new_sum", int'(line_sum), 4);
        chk("bp_new_last", int'(line_last), 1);
        @(negedge CLK);
        #1;
        chk("bp_frame_done", int'(frame_done), 1);

        // Back-to-back lines: no stalls with ready high.
        stalls = 0;
        for (int k = 0; k < 12; k++) send_pixel(8'($urandom), 8'($urandom));
        chk("b2b_no_stall", stalls, 0);

        // Randomized traffic, including occasional resets; the monitor checks each cycle.
        for (int c = 0; c < 600; c++) begin
            @(negedge CLK);
            pixel_a        = 8'($urandom);
            pixel_b        = 8'($urandom);
            pixel_valid    = ($urandom_range(0, 3) != 0);
            line_sum_ready = ($urandom_range(0, 3) != 0);
            reset          = ($urandom_range(0, 149) == 0);
        end
        @(negedge CLK);
        pixel_valid    = 1'b0;
        line_sum_ready = 1'b1;
        reset          = 1'b0;
        repeat (4) @(negedge CLK);

        // Reset mid-line discards the partial sum.
        send_pixel(8'd3, 8'd3);
        send_pixel(8'd3, 8'd3);
        @(negedge CLK);
        reset = 1'b1;
        #1;
        chk("mid_rst_ready", int'(pixel_ready), 0);
        @(negedge CLK);
        reset = 1'b0;
        #1;
        chk("mid_rst_valid", int'(line_sum_valid), 0);
        chk("mid_rst_sum", int'(line_sum), 0);
        chk("mid_rst_last", int'(line_last), 0);
        chk("mid_rst_frame_done", int'(frame_done), 0);
        send_line(32'h01010101, 32'h01010101);
        @(negedge CLK);
        #1;
        chk("after_rst_valid", int'(line_sum_valid), 1);
        chk("after_rst_sum", int'(line_sum), 4);
        chk("after_rst_last", int'(line_last), 0);

        repeat (4) @(negedge CLK);
        chk("model_drained", int'(exp_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
